filter_ctrl: RTL and testbench
==============================

// Module: filter_ctrl
// PURPOSE
//  Frame sequencer for the sample filter datapath. On a capture-complete pulse it streams one
//  frame from capture RAM through a streaming filter core into a ping-pong result RAM.
//  It latches filter mode per frame, counts results, then hands the finished bank to display.
//  Sits between the capture buffer (upstream) and the display reader (downstream).
// PARAMETERS
//  N_SAMPLES  256                  samples per frame (power of 2, >=4)
//  DW         12                   sample width, unsigned offset-binary
//  AW         $clog2(N_SAMPLES)    sample address width
// PORTS
//  clk            in   1   clock
//  rst            in   1   reset, synchronous, active-high
//  start          in   1   1-cycle pulse: capture RAM holds a complete frame
//  mode_req       in   1   requested mode, 0=low-pass 1=high-pass
//  busy           out  1   frame in progress
//  done           out  1   1-cycle pulse when last result is written
//  overrun        out  1   1-cycle pulse when start arrives while busy
//  rd_en          out  1   capture RAM read strobe
//  rd_addr        out  AW  capture RAM address; rd_data valid the cycle after rd_en
//  rd_data        in   DW  capture RAM data
//  core_in_valid  out  1   sample valid to filter core (core accepts every cycle)
//  core_in_first  out  1   marks sample 0; core clears its y_prev state
//  core_in_data   out  DW  sample to core
//  core_mode      out  1   latched frame mode
//  core_out_valid in   1   result valid from core (fixed latency >=1, order preserved)
//  core_out_data  in   DW  filtered result
//  wr_en          out  1   result RAM write strobe
//  wr_addr        out  AW+1  {wr_bank, index}
//  wr_data        out  DW  result to RAM
//  disp_bank      out  1   bank the display may read (= ~wr_bank)
// BEHAVIOUR
//  FSM: IDLE -> FEED on start; FEED -> DRAIN after read N_SAMPLES-1 issued;
//   DRAIN -> DONE when N_SAMPLES results written; DONE -> IDLE next cycle.
//  Reset: state=IDLE, wr_bank=0 (disp_bank=1). Counters=0. busy, done, overrun, rd_en,
//   core_in_valid, core_in_first, wr_en = 0. core_mode=0.
//  On start in IDLE: core_mode<=mode_req. rd_addr<=0, rd_en=1 the next cycle.
//  mode_req is ignored until the next accepted start.
//  FEED: one read per cycle, rd_addr 0..N_SAMPLES-1, no gaps. rd_addr wraps to 0 only via a new frame.
//  core_in_valid = rd_en delayed 1 cycle. core_in_data = rd_data.
//  core_in_first is high with sample 0 only.
//  Each core_out_valid: wr_en=1, wr_data=core_out_data, wr_addr={wr_bank,out_cnt}; out_cnt++.
//   Writes are combinational pass-through, same cycle.
//  Results beyond N_SAMPLES in a frame, or core_out_valid in IDLE, are discarded with wr_en=0.
//  DONE: done=1 for one cycle and wr_bank toggles, so disp_bank flips the same edge.
//   busy falls the cycle after DONE.
//  busy=1 in FEED, DRAIN and DONE.
//  start while busy: frame is not restarted; overrun pulses 1 cycle.
//  start in the same cycle as the DONE->IDLE transition counts as busy (dropped, overrun).
//  Reset mid-frame: immediate return to IDLE. The partial bank is not handed over; disp_bank returns to 1.
//  Throughput: N_SAMPLES + core latency + 2 cycles from start to done.
// CONFIGURATION
//  FILTER_CTRL_BYPASS_EN defined: adds input bypass (1 bit), latched at start like mode_req.
//   When the latched bypass=1, rd_data is written straight to the result RAM, 1 cycle after rd_en.
//   The core is not fed (core_in_valid=0) and core_out_valid is ignored.
//   Frame length is N_SAMPLES+2 cycles.
//  Not defined: no bypass port; all frames go through the core.
// TESTING
//  Reset, idle 10 cycles -> busy=0, wr_en=0, rd_en=0, disp_bank=1.
//  start with mode_req=1; core model latency 3, y=x^12'h0FF -> 256 writes to bank 0,
//   addr 0..255 in order. done pulses once at cycle 256+3+2. disp_bank=0 after.
//   core_mode=1 throughout; core_in_first high only with addr 0.
//  Toggle mode_req every cycle mid-frame -> core_mode constant; second frame writes to bank 1,
//   disp_bank back to 1.
//  start at cycles +1, +100 and on the DONE cycle -> frame unchanged; 3 overrun pulses; 1 done.
//  rst at sample 128 -> IDLE next cycle, no done, disp_bank=1; a fresh start writes bank 0 from addr 0.
//  FILTER_CTRL_BYPASS_EN, bypass=1, ramp 0..255 -> result RAM = ramp; core_in_valid never high.

Source files
------------

// File: rtl/filter_ctrl.sv
// Frame sequencer: streams one capture-RAM frame through the filter core into a ping-pong result RAM.
// Optional input bypass path is enabled with `define FILTER_CTRL_BYPASS_EN.
module filter_ctrl #(
  parameter int N_SAMPLES = 256,
  parameter int DW        = 12,
  parameter int AW        = $clog2(N_SAMPLES)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            mode_req,
`ifdef FILTER_CTRL_BYPASS_EN
  input  logic            bypass,
`endif
  output logic            busy,
  output logic            done,
  output logic            overrun,
  output logic            rd_en,
  output logic [AW-1:0]   rd_addr,
  input  logic [DW-1:0]   rd_data,
  output logic            core_in_valid,
  output logic            core_in_first,
  output logic [DW-1:0]   core_in_data,
  output logic            core_mode,
  input  logic            core_out_valid,
  input  logic [DW-1:0]   core_out_data,
  output logic            wr_en,
  output logic [AW:0]     wr_addr,
  output logic [DW-1:0]   wr_data,
  output logic            disp_bank
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [AW:0]   N_CNT     = (AW+1)'(N_SAMPLES);
  localparam logic [AW:0]   LAST_CNT  = (AW+1)'(N_SAMPLES - 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(N_SAMPLES - 1);

  state_t          state_r;
  logic [AW:0]     out_cnt_r;
  logic [AW-1:0]   rd_addr_r;
  logic            wr_bank_r;
  logic            busy_r;
  logic            done_r;
  logic            overrun_r;
  logic            rd_en_r;
  logic            in_vld_r;
  logic            in_first_r;
  logic            mode_r;
  logic            bypass_s;
  logic            src_valid_s;
  logic [DW-1:0]   src_data_s;
  logic            frame_act_s;
  logic            wr_en_s;
  logic            last_wr_s;

`ifdef FILTER_CTRL_BYPASS_EN
  logic            bypass_r;
  assign bypass_s = bypass_r;
`else
  assign bypass_s = 1'b0;
`endif

  // Result source select and write qualification (writes pass straight through).
  always_comb begin
    src_valid_s = core_out_valid;
    src_data_s  = core_out_data;
    if (bypass_s) begin
      src_valid_s = in_vld_r;
      src_data_s  = rd_data;
    end else begin
      src_valid_s = core_out_valid;
      src_data_s  = core_out_data;
    end
    frame_act_s = (state_r == FEED) || (state_r == DRAIN);
    wr_en_s     = src_valid_s && frame_act_s && (out_cnt_r < N_CNT);
    last_wr_s   = wr_en_s && (out_cnt_r == LAST_CNT);
  end

  // Frame sequencing FSM with all registered control outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      out_cnt_r  <= '0;
      rd_addr_r  <= '0;
      wr_bank_r  <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      overrun_r  <= 1'b0;
      rd_en_r    <= 1'b0;
      in_vld_r   <= 1'b0;
      in_first_r <= 1'b0;
      mode_r     <= 1'b0;
`ifdef FILTER_CTRL_BYPASS_EN
      bypass_r   <= 1'b0;
`endif
    end else begin
      done_r     <= 1'b0;
      // A start in any non-idle state, including DONE, is dropped.
      overrun_r  <= start && (state_r != IDLE);
      in_vld_r   <= rd_en_r;
      in_first_r <= rd_en_r && (rd_addr_r == '0);
      if (wr_en_s) begin
        out_cnt_r <= out_cnt_r + 1'b1;
      end
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r   <= FEED;
            mode_r    <= mode_req;
`ifdef FILTER_CTRL_BYPASS_EN
            bypass_r  <= bypass;
`endif
            rd_en_r   <= 1'b1;
            rd_addr_r <= '0;
            out_cnt_r <= '0;
            busy_r    <= 1'b1;
          end
        end
        FEED: begin
          if (rd_addr_r == LAST_ADDR) begin
            rd_en_r <= 1'b0;
            state_r <= DRAIN;
          end else begin
            rd_addr_r <= rd_addr_r + 1'b1;
          end
        end
        DRAIN: begin
          if (last_wr_s) begin
            state_r   <= DONE;
            done_r    <= 1'b1;
            wr_bank_r <= ~wr_bank_r;
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          rd_en_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy          = busy_r;
  assign done          = done_r;
  assign overrun       = overrun_r;
  assign rd_en         = rd_en_r;
  assign rd_addr       = rd_addr_r;
  assign core_in_valid = in_vld_r && !bypass_s;
  assign core_in_first = in_first_r && !bypass_s;
  assign core_in_data  = rd_data;
  assign core_mode     = mode_r;
  assign wr_en         = wr_en_s;
  assign wr_addr       = {wr_bank_r, out_cnt_r[AW-1:0]};
  assign wr_data       = src_data_s;
  assign disp_bank     = ~wr_bank_r;

endmodule

// File: tb/tb_filter_ctrl.sv
// Randomized self-checking bench for filter_ctrl: capture RAM and 3-cycle core models drive the DUT,
// a frame-timeline model predicts every output each cycle.
module tb_filter_ctrl;

  localparam int N   = 256;
  localparam int DW  = 12;
  localparam int AW  = 8;
  localparam int LAT = 3;
  localparam int D   = N + LAT + 2;

  logic          clk = 1'b0;
  logic          rst, start, mode_req;
  logic          bypass = 1'b0;
  logic          busy, done, overrun, rd_en, core_in_valid, core_in_first, core_mode;
  logic          core_out_valid, wr_en, disp_bank;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data, core_in_data, core_out_data, wr_data;
  logic [AW:0]   wr_addr;

  logic [DW-1:0] ram [N];
  logic [2:0]    pv = 3'b000;
  logic [DW-1:0] pd [3];

  int cyc = 0, n_chk = 0, n_pass = 0;
  bit mon_en = 1'b0;
  bit m_active = 1'b0, m_bank = 1'b0, m_mode = 1'b0, m_byp = 1'b0, m_ovr = 1'b0;
  int m_rel = 0;
  int n_wr = 0, n_wr_b1 = 0, n_done = 0, n_ovr = 0, n_civ = 0, n_cif = 0;
  int t_start = 0, t_done = 0;
  bit first_seen = 1'b0;
  logic [AW:0]   first_addr;
  logic [DW-1:0] first_data;

  filter_ctrl #(.N_SAMPLES(N), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .mode_req(mode_req),
`ifdef FILTER_CTRL_BYPASS_EN
    .bypass(bypass),
`endif
    .busy(busy), .done(done), .overrun(overrun), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .core_in_valid(core_in_valid), .core_in_first(core_in_first),
    .core_in_data(core_in_data), .core_mode(core_mode), .core_out_valid(core_out_valid),
    .core_out_data(core_out_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .disp_bank(disp_bank)
  );

  always #5 clk = ~clk;

  // capture RAM (1-cycle read) and filter core y = x ^ 0x0FF with fixed latency 3
  always @(posedge clk) begin
    if (rd_en === 1'b1) rd_data <= ram[rd_addr];
    pv    <= {pv[1:0], core_in_valid === 1'b1};
    pd[0] <= core_in_data ^ 12'h0FF;
    pd[1] <= pd[0];
    pd[2] <= pd[1];
  end
  assign core_out_valid = pv[2];
  assign core_out_data  = pd[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Timeline model: rel = cycles since the accepting start; all outputs follow from rel.
  always @(negedge clk) begin
    int lat, d, idx;
    bit e_rd, e_civ, e_wr;
    cyc++;
    lat   = m_byp ? 0 : LAT;
    d     = N + lat + 2;
    e_rd  = m_active && m_rel <= N;
    e_civ = m_active && !m_byp && m_rel >= 2 && m_rel <= N + 1;
    e_wr  = m_active && m_rel >= lat + 2 && m_rel <= lat + N + 1;
    idx   = m_rel - lat - 2;
    if (mon_en) begin
      chk("busy", 32'(busy), 32'(m_active));
      chk("done", 32'(done), 32'(m_active && m_rel == d));
      chk("overrun", 32'(overrun), 32'(m_ovr));
      chk("rd_en", 32'(rd_en), 32'(e_rd));
      chk("core_in_valid", 32'(core_in_valid), 32'(e_civ));
      chk("core_in_first", 32'(core_in_first), 32'(e_civ && m_rel == 2));
      chk("core_mode", 32'(core_mode), 32'(m_mode));
      chk("wr_en", 32'(wr_en), 32'(e_wr));
      chk("disp_bank", 32'(disp_bank), 32'(!m_bank));
      if (e_rd) chk("rd_addr", 32'(rd_addr), 32'(m_rel - 1));
      if (e_civ) chk("core_in_data", 32'(core_in_data), 32'(ram[m_rel - 2]));
      if (e_wr) begin
        chk("wr_addr", 32'(wr_addr), 32'(int'(m_bank) * N + idx));
        chk("wr_data", 32'(wr_data), 32'(m_byp ? ram[idx] : ram[idx] ^ 12'h0FF));
      end
      if (wr_en === 1'b1) begin
        n_wr++;
        if (wr_addr[AW] === 1'b1) n_wr_b1++;
        if (!first_seen) begin
          first_addr = wr_addr;
          first_data = wr_data;
          first_seen = 1'b1;
        end
      end
      if (done === 1'b1) begin n_done++; t_done = cyc; end
      if (overrun === 1'b1) n_ovr++;
      if (core_in_valid === 1'b1) n_civ++;
      if (core_in_first === 1'b1) n_cif++;
    end
    if (rst) begin
      m_active = 1'b0; m_bank = 1'b0; m_mode = 1'b0; m_byp = 1'b0; m_ovr = 1'b0;
    end else begin
      m_ovr = start && m_active;
      if (m_active) begin
        m_rel++;
        if (m_rel == d) m_bank = !m_bank;
        if (m_rel > d) m_active = 1'b0;
      end else if (start) begin
        m_active = 1'b1; m_rel = 1; m_mode = mode_req; m_byp = bypass;
        t_start = cyc; first_seen = 1'b0;
      end
    end
  end

  task automatic fill_random();
    for (int i = 0; i < N; i++) ram[i] = DW'($urandom_range(0, 4095));
  endtask

  initial begin
    int wr0, b10, dn0, ov0, civ0, cif0;
    rst = 1'b1; start = 1'b0; mode_req = 1'b0;
    fill_random();
    ram[0] = 12'h123;
    repeat (3) tick();
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (10) tick();
    chk("idle_busy", 32'(busy), 32'h0);
    chk("idle_wr_en", 32'(wr_en), 32'h0);
    chk("idle_rd_en", 32'(rd_en), 32'h0);
    chk("idle_disp_bank", 32'(disp_bank), 32'h1);

    // frame 1: high-pass, bank 0
    wr0 = n_wr; b10 = n_wr_b1; dn0 = n_done; cif0 = n_cif;
    start = 1'b1; mode_req = 1'b1; tick(); start = 1'b0;
    repeat (D + 4) tick();
    chk("f1_writes", 32'(n_wr - wr0), 32'd256);
    chk("f1_bank1_writes", 32'(n_wr_b1 - b10), 32'd0);
    chk("f1_done_count", 32'(n_done - dn0), 32'd1);
    chk("f1_done_latency", 32'(t_done - t_start), 32'd261);
    chk("f1_first_addr", 32'(first_addr), 32'h000);
    chk("f1_first_data", 32'(first_data), 32'h1DC);
    chk("f1_first_count", 32'(n_cif - cif0), 32'd1);
    chk("f1_disp_bank", 32'(disp_bank), 32'h0);

    // frame 2: mode_req toggles every cycle, bank 1
    fill_random();
    wr0 = n_wr; b10 = n_wr_b1;
    start = 1'b1; mode_req = 1'b0; tick(); start = 1'b0;
    for (int i = 0; i < D + 4; i++) begin mode_req = !mode_req; tick(); end
    chk("f2_bank1_writes", 32'(n_wr_b1 - b10), 32'd256);
    chk("f2_first_addr", 32'(first_addr), 32'h100);
    chk("f2_disp_bank", 32'(disp_bank), 32'h1);

    // frame 3: extra starts at +1, +100 and on the DONE cycle
    wr0 = n_wr; dn0 = n_done; ov0 = n_ovr;
    for (int i = 0; i <= D + 4; i++) begin
      start = (i == 0 || i == 1 || i == 100 || i == D);
      mode_req = 1'($urandom_range(0, 1));
      tick();
    end
    start = 1'b0;
    chk("f3_overruns", 32'(n_ovr - ov0), 32'd3);
    chk("f3_done_count", 32'(n_done - dn0), 32'd1);
    chk("f3_writes", 32'(n_wr - wr0), 32'd256);

    // frame 4: reset at sample 128
    dn0 = n_done;
    start = 1'b1; tick(); start = 1'b0;
    repeat (129) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_rd_en", 32'(rd_en), 32'h0);
    chk("rst_disp_bank", 32'(disp_bank), 32'h1);
    repeat (10) tick();
    chk("rst_no_done", 32'(n_done - dn0), 32'd0);

    // frame 5: fresh start after reset writes bank 0 from addr 0
    wr0 = n_wr; dn0 = n_done;
    start = 1'b1; tick(); start = 1'b0;
    repeat (D + 4) tick();
    chk("f5_first_addr", 32'(first_addr), 32'h000);
    chk("f5_writes", 32'(n_wr - wr0), 32'd256);
    chk("f5_done_count", 32'(n_done - dn0), 32'd1);

`ifdef FILTER_CTRL_BYPASS_EN
    // bypass frame: ramp written straight through, core untouched
    for (int i = 0; i < N; i++) ram[i] = DW'(i);
    wr0 = n_wr; civ0 = n_civ;
    start = 1'b1; bypass = 1'b1; tick(); start = 1'b0; bypass = 1'b0;
    repeat (N + 6) tick();
    chk("byp_core_valid", 32'(n_civ - civ0), 32'd0);
    chk("byp_writes", 32'(n_wr - wr0), 32'd256);
    chk("byp_done_latency", 32'(t_done - t_start), 32'd258);
    chk("byp_first_data", 32'(first_data), 32'h000);
`else
    civ0 = n_civ;
    chk("civ_counter_live", 32'(civ0 > 0), 32'h1);
`endif

    // random phase: sporadic starts, random mode (and bypass when built in)
    fill_random();
    for (int i = 0; i < 1500; i++) begin
      start = ($urandom_range(0, 39) == 0);
      mode_req = 1'($urandom_range(0, 1));
`ifdef FILTER_CTRL_BYPASS_EN
      bypass = 1'($urandom_range(0, 1));
`endif
      tick();
    end
    start = 1'b0;
    repeat (D + 10) tick();
    chk("end_idle_busy", 32'(busy), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
